// File: rtl/ternary_adder_arbiter_if.sv
// rtl/ternary_adder_arbiter_if.sv - Request and result channels of the shared ternary adder
interface ternary_adder_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_x;
  logic [7:0] req0_y;
  logic       req0_cin;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_x;
  logic [7:0] req1_y;
  logic       req1_cin;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_sum;
  logic       res_cout;
  logic       res_id;
  logic       res_err;

  modport master (
    output req0_valid, req0_x, req0_y, req0_cin,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_cin,
    input  req1_ready,
    input  res_valid, res_sum, res_cout, res_id, res_err,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_cin,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_cin,
    output req1_ready,
    output res_valid, res_sum, res_cout, res_id, res_err,
    input  res_ready
  );
endinterface

// File: rtl/ternary_adder_arbiter.sv
// rtl/ternary_adder_arbiter.sv - Round-robin arbiter sharing one 4-digit ternary adder between two requesters
// Optional illegal-digit checking is built when TERNARY_ADDER_ARBITER_DIGIT_CHECK_EN is defined.

module ternary_full_adder_4digit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    logic [2:0] t;
    logic [2:0] t_wrap;
    assign t      = {1'b0, x[2*i +: 2]} + {1'b0, y[2*i +: 2]} + {2'b00, carry[i]};
    assign t_wrap = t - 3'd3;
    assign sum[2*i +: 2] = (t >= 3'd3) ? t_wrap[1:0] : t[1:0];
    assign carry[i+1]    = (t >= 3'd3);
  end

  assign cout = carry[4];
endmodule

module ternary_adder_arbiter (
  input  logic                        clk,
  input  logic                        rst_n,
  ternary_adder_arbiter_if.slave      bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       last_q;
  logic       grant_id;
  logic       accept;
  logic [7:0] op_x_q, op_y_q;
  logic       op_cin_q, op_id_q;
  logic [7:0] add_sum, cap_sum;
  logic       add_cout, cap_cout;
  logic [7:0] res_sum_q;
  logic       res_cout_q, res_id_q;

  // On a tie the requester that did not win last time is served.
  assign grant_id = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          state_d        = BUSY;
        end
      end
      BUSY:    state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      op_x_q   <= 8'h00;
      op_y_q   <= 8'h00;
      op_cin_q <= 1'b0;
      op_id_q  <= 1'b0;
    end else if (accept) begin
      last_q   <= grant_id;
      op_x_q   <= grant_id ? bus.req1_x   : bus.req0_x;
      op_y_q   <= grant_id ? bus.req1_y   : bus.req0_y;
      op_cin_q <= grant_id ? bus.req1_cin : bus.req0_cin;
      op_id_q  <= grant_id;
    end
  end

  ternary_full_adder_4digit u_adder (
    .x    (op_x_q),
    .y    (op_y_q),
    .cin  (op_cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef TERNARY_ADDER_ARBITER_DIGIT_CHECK_EN
  logic illegal;
  logic res_err_q;

  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (op_x_q[2*i +: 2] == 2'b11 || op_y_q[2*i +: 2] == 2'b11) illegal = 1'b1;
    end
  end

  assign cap_sum  = illegal ? 8'h00 : add_sum;
  assign cap_cout = illegal ? 1'b0  : add_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err_q <= 1'b0;
    end else if (state_q == BUSY) begin
      res_err_q <= illegal;
    end
  end

  assign bus.res_err = res_err_q;
`else
  assign cap_sum     = add_sum;
  assign cap_cout    = add_cout;
  assign bus.res_err = 1'b0;
`endif

  // Result registers only load in BUSY, so they hold steady through DONE backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_q  <= 8'h00;
      res_cout_q <= 1'b0;
      res_id_q   <= 1'b0;
    end else if (state_q == BUSY) begin
      res_sum_q  <= cap_sum;
      res_cout_q <= cap_cout;
      res_id_q   <= op_id_q;
    end
  end

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_ternary_adder_arbiter.sv
// tb/tb_ternary_adder_arbiter.sv - Randomized self-checking bench for ternary_adder_arbiter
module tb_ternary_adder_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ternary_adder_arbiter_if bus();

  ternary_adder_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  logic last_model;

  function automatic int t2i(input logic [7:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 3 + int'(v[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [7:0] i2t(input int n);
    logic [7:0] r;
    int m = n;
    for (int i = 0; i < 4; i++) begin
      r[2*i +: 2] = 2'(m % 3);
      m = m / 3;
    end
    return r;
  endfunction

  function automatic logic [7:0] rand_t();
    return i2t(int'($urandom_range(0, 80)));
  endfunction

  function automatic logic [8:0] model_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    int total = t2i(x) + t2i(y) + int'(c);
    return {(total >= 81), i2t(total % 81)};
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_x = 8'h00; bus.req0_y = 8'h00; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_x = 8'h00; bus.req1_y = 8'h00; bus.req1_cin = 1'b0;
    bus.res_ready  = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_model = 1'b1;
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [7:0] x, input logic [7:0] y, input logic c);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_cin = c;
    end else begin
      bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_cin = c;
    end
  endtask

  task automatic run_op(input bit id, input logic [7:0] x, input logic [7:0] y, input logic c,
                        output logic [7:0] s, output logic co, output logic rid, output logic er,
                        output int lat, output bit ok);
    bit got = 0;
    bit seen = 0;
    ok = 0; lat = 0; s = 8'h00; co = 1'b0; rid = 1'b0; er = 1'b0;
    @(negedge clk);
    drive_req(id, 1'b1, x, y, c);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      drive_req(id, 1'b0, 8'h00, 8'h00, 1'b0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drive_req(id, 1'b0, 8'h00, 8'h00, 1'b0);
    last_model = id;
    for (int i = 1; i <= 10 && !seen; i++) begin
      #1;
      if (bus.res_valid) begin
        seen = 1; lat = i; ok = 1;
        s = bus.res_sum; co = bus.res_cout; rid = bus.res_id; er = bus.res_err;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b want 0", bus.req1_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    checks++; if (bus.res_sum !== 8'h00) begin errors++; $display("FAIL reset_res_sum got %h want 00", bus.res_sum); end
    checks++; if ({bus.res_cout, bus.res_id, bus.res_err} !== 3'b000) begin
      errors++; $display("FAIL reset_res_flags got %b want 000", {bus.res_cout, bus.res_id, bus.res_err});
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    last_model = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] s; logic co, rid, er; int lat; bit ok;
    run_op(1'b0, 8'h12, 8'h05, 1'b0, s, co, rid, er, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got timeout want result"); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", lat); end
    checks++; if ({s, co, rid} !== {8'h18, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_cin0 got sum=%h cout=%b id=%b want 18 0 0", s, co, rid);
    end
    run_op(1'b0, 8'h12, 8'h05, 1'b1, s, co, rid, er, lat, ok);
    checks++; if (!ok || s !== 8'h19 || co !== 1'b0) begin
      errors++; $display("FAIL single_cin1 got ok=%b sum=%h cout=%b want 19 0", ok, s, co);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] s; logic co, rid, er; int lat; bit ok;
    run_op(1'b1, 8'hAA, 8'h01, 1'b0, s, co, rid, er, lat, ok);
    checks++; if (!ok || {s, co, rid} !== {8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL overflow got ok=%b sum=%h cout=%b id=%b want 00 1 1", ok, s, co, rid);
    end
  endtask

  task automatic test_random();
    logic [7:0] s, x, y; logic co, rid, er, c; int lat; bit ok, id; logic [8:0] e;
    for (int n = 0; n < 24; n++) begin
      id = 1'($urandom_range(0, 1));
      x  = rand_t();
      y  = rand_t();
      c  = 1'($urandom_range(0, 1));
      e  = model_add(x, y, c);
      run_op(id, x, y, c, s, co, rid, er, lat, ok);
      checks++; if (!ok || lat !== 2 || {co, s} !== e || rid !== id || er !== 1'b0) begin
        errors++;
        $display("FAIL random_op%0d got ok=%b lat=%0d cout=%b sum=%h id=%b err=%b want cout=%b sum=%h id=%b",
                 n, ok, lat, co, s, rid, er, e[8], e[7:0], id);
      end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] x[2], y[2]; logic c[2];
    logic [9:0] expq[$];
    logic [9:0] ev;
    int grants = 0, last_cyc = -1, cyc = 0, results = 0;
    bit r0, r1, gid, granted;
    apply_reset();
    for (int k = 0; k < 2; k++) begin x[k] = rand_t(); y[k] = rand_t(); c[k] = 1'($urandom_range(0, 1)); end
    drive_req(1'b0, 1'b1, x[0], y[0], c[0]);
    drive_req(1'b1, 1'b1, x[1], y[1], c[1]);
    while (grants < 8 && cyc < 100) begin
      #1;
      r0 = bus.req0_ready; r1 = bus.req1_ready; granted = 0; gid = r1;
      if (bus.res_valid && expq.size() > 0) begin
        ev = expq.pop_front();
        results++;
        checks++; if ({bus.res_id, bus.res_cout, bus.res_sum} !== ev) begin
          errors++; $display("FAIL fair_result got id=%b cout=%b sum=%h want id=%b cout=%b sum=%h",
                             bus.res_id, bus.res_cout, bus.res_sum, ev[9], ev[8], ev[7:0]);
        end
      end
      if (r0 && r1) begin errors++; checks++; $display("FAIL fair_both_ready got 11 want one-hot"); end
      if (r0 || r1) begin
        granted = 1;
        checks++; if (gid !== ~last_model) begin errors++; $display("FAIL fair_order got %b want %b", gid, ~last_model); end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL fair_gap got %0d want 3", cyc - last_cyc); end
        end
        expq.push_back({gid, model_add(x[gid], y[gid], c[gid])});
        last_model = gid;
        last_cyc = cyc;
        grants++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (granted) begin
        x[gid] = rand_t(); y[gid] = rand_t(); c[gid] = 1'($urandom_range(0, 1));
        drive_req(gid, 1'b1, x[gid], y[gid], c[gid]);
      end
    end
    checks++; if (grants != 8 || results < 6) begin
      errors++; $display("FAIL fair_count got grants=%0d results=%0d want 8 >=6", grants, results);
    end
    idle_inputs();
    apply_reset();
  endtask

  task automatic test_backpressure();
    logic [7:0] x2, y2, s; logic c2; logic [8:0] e1, e2; logic [11:0] snap; bit got = 0, seen = 0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    e1 = model_add(8'h21, 8'h12, 1'b1);
    drive_req(1'b0, 1'b1, 8'h21, 8'h12, 1'b1);
    for (int i = 0; i < 10 && !got; i++) begin #1; if (bus.req0_ready) got = 1; else @(negedge clk); end
    checks++; if (!got) begin errors++; $display("FAIL bp_accept got no ready want ready"); end
    @(posedge clk);
    @(negedge clk);
    x2 = rand_t(); y2 = rand_t(); c2 = 1'($urandom_range(0, 1));
    e2 = model_add(x2, y2, c2);
    drive_req(1'b0, 1'b1, x2, y2, c2);
    for (int i = 0; i < 10 && !seen; i++) begin #1; if (bus.res_valid) seen = 1; else @(negedge clk); end
    snap = {bus.res_valid, bus.res_id, bus.res_err, bus.res_cout, bus.res_sum};
    checks++; if (snap !== {1'b1, 1'b0, 1'b0, e1}) begin
      errors++; $display("FAIL bp_first got %h want %h", snap, {1'b1, 1'b0, 1'b0, e1});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.res_valid, bus.res_id, bus.res_err, bus.res_cout, bus.res_sum, bus.req0_ready, bus.req1_ready}
          !== {snap, 2'b00}) begin
        errors++; $display("FAIL bp_hold%0d got %h rdy=%b%b want %h rdy=00", i,
                           {bus.res_valid, bus.res_id, bus.res_err, bus.res_cout, bus.res_sum},
                           bus.req0_ready, bus.req1_ready, snap);
      end
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_resume got rdy0=%b valid=%b want 1 0", bus.req0_ready, bus.res_valid);
    end
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    last_model = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin #1; if (bus.res_valid) seen = 1; else @(negedge clk); end
    s = bus.res_sum;
    checks++; if (!seen || {bus.res_cout, s} !== e2) begin
      errors++; $display("FAIL bp_second got seen=%b cout=%b sum=%h want %b %h", seen, bus.res_cout, s, e2[8], e2[7:0]);
    end
  endtask

  task automatic test_reset_mid();
    bit got = 0, stale = 0, seen = 0;
    @(negedge clk);
    drive_req(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 10 && !got; i++) begin #1; if (bus.req1_ready) got = 1; else @(negedge clk); end
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (!got || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid got accepted=%b valid=%b want 1 0", got, bus.res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_model = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (bus.res_valid) stale = 1;
    end
    checks++; if (stale) begin errors++; $display("FAIL rstmid_stale got res_valid=1 want 0"); end
    @(negedge clk);
    drive_req(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    drive_req(1'b1, 1'b1, 8'h02, 8'h02, 1'b0);
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== {1'b1, 1'b0}) begin
      errors++; $display("FAIL rstmid_tie got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    last_model = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin #1; if (bus.res_valid) seen = 1; else @(negedge clk); end
    checks++; if (!seen || {bus.res_id, bus.res_sum} !== {1'b0, 8'h02}) begin
      errors++; $display("FAIL rstmid_result got seen=%b id=%b sum=%h want 1 0 02", seen, bus.res_id, bus.res_sum);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] s; logic co, rid, er; int lat; bit ok;
    run_op(1'b0, 8'hC0, 8'h01, 1'b0, s, co, rid, er, lat, ok);
`ifdef TERNARY_ADDER_ARBITER_DIGIT_CHECK_EN
    checks++; if (!ok || {er, s, co} !== {1'b1, 8'h00, 1'b0}) begin
      errors++; $display("FAIL illegal_check got ok=%b err=%b sum=%h cout=%b want 1 00 0", ok, er, s, co);
    end
`else
    checks++; if (!ok || er !== 1'b0) begin
      errors++; $display("FAIL illegal_noerr got ok=%b err=%b want 0", ok, er);
    end
`endif
  endtask

  initial begin
    last_model = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_random();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_illegal();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
